fifo_bus_sel_arbiter: RTL and testbench
=======================================

Name: fifo_bus_sel_arbiter

Overview:
- Sits on the FIFO side of the bus_sel interconnect, one instance per output FIFO.
- Receives the transposed select vector: bit x means frame distributor fd_x wants this FIFO.
- Arbitrates round-robin among requesting fds and holds the grant for one whole packet.
- Muxes the granted fd's data stream into the FIFO write port with registered outputs, and returns per-fd ready/grant.

Parameters:
- PORT_NUM, 10, number of fd ports (request vector width).
- DATA_W, 8, data word width per fd.
- ID_W, 4, width of grant_id; must be >= clog2(PORT_NUM).
- TIMEOUT, 255, idle cycles under grant before forced release; 0 disables.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bus_sel  in  PORT_NUM  request vector from the interconnect; bit x = fd_x requests this FIFO.
- fd_valid  in  PORT_NUM  per-fd data valid.
- fd_eop  in  PORT_NUM  per-fd end-of-packet, qualified by fd_valid.
- fd_data  in  PORT_NUM*DATA_W  flattened data; fd_x occupies [x*DATA_W +: DATA_W].
- fifo_afull  in  1  FIFO almost-full; asserted while at most one free slot remains.
- fd_ready  out  PORT_NUM  combinational: grant & {PORT_NUM{~fifo_afull}}.
- grant  out  PORT_NUM  registered one-hot grant, all-zero when idle.
- grant_id  out  ID_W  registered binary index of the granted fd; held after release.
- fifo_wr  out  1  registered FIFO write strobe.
- fifo_wdata  out  DATA_W  registered FIFO write data.
- timeout_pulse  out  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst_n=0):
  - grant=0, grant_id=0, fifo_wr=0, fifo_wdata=0, timeout_pulse=0.
  - Round-robin pointer rr_last=PORT_NUM-1, so fd_0 has first priority.
  - Idle counter=0, state=IDLE.
  - Reset asserted mid-packet drops the grant immediately. No partial-packet cleanup is done; that is the upstream's responsibility.
- States:
  - IDLE -> BUSY when |bus_sel. The winner is the first set bit scanning from rr_last+1 upward, wrapping modulo PORT_NUM.
  - grant and grant_id update on the same edge as IDLE->BUSY, one cycle after the request is seen.
  - BUSY -> IDLE on any of:
    - (a) transfer with fd_eop[grant_id]=1;
    - (b) bus_sel[grant_id]=0 with no transfer that cycle (abort);
    - (c) idle counter reaches TIMEOUT (when TIMEOUT != 0).
  - On every BUSY->IDLE transition: grant clears and rr_last<=grant_id.
  - After release, IDLE lasts at least one cycle, so there is always a one-cycle bubble between packets, even if requests are pending.
- Transfer: in BUSY, occurs when fd_valid[grant_id] && fd_ready[grant_id].
  - On the next edge: fifo_wr=1 and fifo_wdata=fd_data slice of grant_id.
  - Otherwise fifo_wr=0 and fifo_wdata holds its value.
  - Latency is 1 cycle from transfer to write.
  - The one-slot headroom in fifo_afull absorbs this registered write.
- Valid on a non-granted fd is ignored; that fd's fd_ready is 0.
- Idle counter:
  - Counts BUSY cycles with no transfer.
  - Clears on any transfer and on entering BUSY.
  - Saturates at TIMEOUT.
  - Stalls caused by fifo_afull still count.
- Forced release (c): timeout_pulse=1 on the release edge only.
- Simultaneous events:
  - eop transfer and abort condition in the same cycle: treated as a normal eop release; no timeout pulse.
  - Timeout and transfer in the same cycle cannot occur, because a transfer clears the counter.
- Multiple bits of bus_sel set is legal; only one grant is ever issued.
- bus_sel bits other than grant_id changing during BUSY have no effect.

Test Plan:
- Single request: bus_sel=0x004 with fd_2 sending 3 words A1,A2,A3 (eop on A3) -> grant=0x004 and grant_id=2 one cycle later; fifo_wr high 3 cycles with A1..A3, each 1 cycle after its handshake; grant=0 the cycle after the A3 transfer.
- Round-robin: bus_sel=0x209 held, each fd sends 1-word packets -> service order fd_0, fd_3, fd_9, fd_0, with a 1-cycle idle gap between grants.
- Backpressure: fifo_afull=1 for 4 cycles mid-packet -> fd_ready[grant_id]=0, no fifo_wr in those cycles, no word lost or duplicated; TIMEOUT=3 -> forced release with timeout_pulse=1.
- Abort: fd_5 granted, bus_sel[5] drops before eop with no valid -> grant clears next edge, rr_last=5, next request from fd_6 wins over fd_4.
- Async reset mid-packet: pull rst_n low between clock edges -> grant, fifo_wr and timeout_pulse go to 0 immediately; after release, bus_sel=0x3FF grants fd_0 first.

Source files
------------

// File: rtl/fifo_bus_sel_arbiter.sv
// Per-FIFO arbiter for the bus_sel interconnect: round-robin grant held for a
// whole packet, with a registered write mux into the FIFO.
module fifo_bus_sel_arbiter #(
  parameter int PORT_NUM = 10,
  parameter int DATA_W   = 8,
  parameter int ID_W     = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PORT_NUM-1:0]        bus_sel,
  input  logic [PORT_NUM-1:0]        fd_valid,
  input  logic [PORT_NUM-1:0]        fd_eop,
  input  logic [PORT_NUM*DATA_W-1:0] fd_data,
  input  logic                       fifo_afull,
  output logic [PORT_NUM-1:0]        fd_ready,
  output logic [PORT_NUM-1:0]        grant,
  output logic [ID_W-1:0]            grant_id,
  output logic                       fifo_wr,
  output logic [DATA_W-1:0]          fifo_wdata,
  output logic                       timeout_pulse
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e              state_q, state_d;
  logic [PORT_NUM-1:0] grant_q, grant_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                to_q, to_d;

  logic                sel_bus, sel_valid, sel_eop;
  logic [DATA_W-1:0]   sel_data;
  logic [ID_W-1:0]     lo_id, hi_id, win_id;
  logic                hi_found;
  logic                xfer, timeout_hit, release_c;

  always_comb begin
    sel_bus   = 1'b0;
    sel_valid = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      if (gid_q == ID_W'(i)) begin
        sel_bus   = bus_sel[i];
        sel_valid = fd_valid[i];
        sel_eop   = fd_eop[i];
        sel_data  = fd_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Lowest requester above rr_q wins; if none, wrap to the lowest requester.
  always_comb begin
    lo_id    = '0;
    hi_id    = '0;
    hi_found = 1'b0;
    for (int i = PORT_NUM - 1; i >= 0; i--) begin
      if (bus_sel[i]) begin
        lo_id = ID_W'(i);
      end
      if (bus_sel[i] && (ID_W'(i) > rr_q)) begin
        hi_id    = ID_W'(i);
        hi_found = 1'b1;
      end
    end
  end

  assign win_id = hi_found ? hi_id : lo_id;

  assign fd_ready    = grant_q & {PORT_NUM{~fifo_afull}};
  assign xfer        = (state_q == BUSY) && sel_valid && !fifo_afull;
  // Fires on the edge where the stall count would reach TIMEOUT, so it can never
  // coincide with a transfer.
  assign timeout_hit = (TIMEOUT != 0) && (state_q == BUSY) && !xfer &&
                       ((int'(cnt_q) + 1) >= TIMEOUT);
  assign release_c   = (xfer && sel_eop) || timeout_hit || (!sel_bus && !xfer);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    wr_d    = xfer;
    wdata_d = xfer ? sel_data : wdata_q;
    case (state_q)
      IDLE: begin
        if (|bus_sel) begin
          state_d = BUSY;
          gid_d   = win_id;
          cnt_d   = '0;
          for (int j = 0; j < PORT_NUM; j++) begin
            grant_d[j] = (win_id == ID_W'(j));
          end
        end
      end
      BUSY: begin
        if (xfer) begin
          cnt_d = '0;
        end else if (int'(cnt_q) < TIMEOUT) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (release_c) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = gid_q;
          to_d    = timeout_hit;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      rr_q    <= ID_W'(PORT_NUM - 1);
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      to_q    <= to_d;
    end
  end

  assign grant         = grant_q;
  assign grant_id      = gid_q;
  assign fifo_wr       = wr_q;
  assign fifo_wdata    = wdata_q;
  assign timeout_pulse = to_q;

endmodule

// File: tb/tb_fifo_bus_sel_arbiter.sv
// Bench for fifo_bus_sel_arbiter: directed vector table, hand-written corner
// sequences, then random traffic against a packet-level reference model.
module tb_fifo_bus_sel_arbiter;

  localparam int N  = 10;
  localparam int DW = 8;
  localparam int IW = 4;
  localparam int TO = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    bus_sel, fd_valid, fd_eop, fd_ready, grant;
  logic [N*DW-1:0] fd_data;
  logic            fifo_afull;
  logic [IW-1:0]   grant_id;
  logic            fifo_wr;
  logic [DW-1:0]   fifo_wdata;
  logic            timeout_pulse;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_bus_sel_arbiter #(
    .PORT_NUM(N), .DATA_W(DW), .ID_W(IW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel), .fd_valid(fd_valid),
    .fd_eop(fd_eop), .fd_data(fd_data), .fifo_afull(fifo_afull),
    .fd_ready(fd_ready), .grant(grant), .grant_id(grant_id),
    .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata), .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    bit          rst;
    logic [N-1:0] bs, v, e;
    bit          af;
    int          tgt;
    logic [7:0]  w;
    logic [N-1:0] rdy, gnt;
    int          gid;
    bit          wr;
    logic [7:0]  wd;
    bit          to;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] mkdata(input int tgt, input logic [7:0] w);
    logic [N*DW-1:0] r;
    r = '0;
    for (int x = 0; x < N; x++) r[x*DW +: DW] = (x == tgt) ? w : (8'hE0 | 8'(x));
    return r;
  endfunction

  task automatic add(input bit rst, input logic [N-1:0] bs, v, e, input bit af,
                     input int tgt, input logic [7:0] w, input logic [N-1:0] rdy, gnt,
                     input int gid, input bit wr, input logic [7:0] wd, input bit to);
    vec_t r;
    r.rst = rst; r.bs = bs; r.v = v; r.e = e; r.af = af; r.tgt = tgt; r.w = w;
    r.rdy = rdy; r.gnt = gnt; r.gid = gid; r.wr = wr; r.wd = wd; r.to = to;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic [N-1:0] bs, v, e, input bit af, input int tgt,
                       input logic [7:0] w);
    bus_sel = bs; fd_valid = v; fd_eop = e; fifo_afull = af; fd_data = mkdata(tgt, w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, '0, 1'b0, 0, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Reference model state
  bit         m_busy, m_wr, m_to;
  int         m_gid, m_rr, m_idle;
  logic [7:0] m_wd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single request: fd_2 sends A1,A2,A3
    add(1, 'h004, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h004, 2, 0, 'h00, 0);
    add(0, 'h004, 'h004, 'h000, 0, 2, 'hA1, 'h004, 'h004, 2, 1, 'hA1, 0);
    add(0, 'h004, 'h004, 'h000, 0, 2, 'hA2, 'h004, 'h004, 2, 1, 'hA2, 0);
    add(0, 'h004, 'h004, 'h004, 0, 2, 'hA3, 'h004, 'h000, 2, 1, 'hA3, 0);
    add(0, 'h000, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h000, 2, 0, 'hA3, 0);
    // Round-robin over 0x209 with one-word packets
    add(1, 'h209, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h001, 0, 0, 'h00, 0);
    add(0, 'h209, 'h209, 'h001, 0, 0, 'h10, 'h001, 'h000, 0, 1, 'h10, 0);
    add(0, 'h209, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h008, 3, 0, 'h10, 0);
    add(0, 'h209, 'h008, 'h008, 0, 3, 'h20, 'h008, 'h000, 3, 1, 'h20, 0);
    add(0, 'h209, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h200, 9, 0, 'h20, 0);
    add(0, 'h209, 'h200, 'h200, 0, 9, 'h30, 'h200, 'h000, 9, 1, 'h30, 0);
    add(0, 'h209, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h001, 0, 0, 'h30, 0);
    add(0, 'h209, 'h001, 'h001, 0, 0, 'h40, 'h001, 'h000, 0, 1, 'h40, 0);
    // Abort of fd_5, then fd_6 beats fd_4; eop with bus_sel dropped is a normal release
    add(1, 'h020, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h020, 5, 0, 'h00, 0);
    add(0, 'h000, 'h000, 'h000, 0, 0, 'h00, 'h020, 'h000, 5, 0, 'h00, 0);
    add(0, 'h050, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h040, 6, 0, 'h00, 0);
    add(0, 'h000, 'h000, 'h000, 0, 0, 'h00, 'h040, 'h000, 6, 0, 'h00, 0);
    add(0, 'h080, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h080, 7, 0, 'h00, 0);
    add(0, 'h000, 'h080, 'h080, 0, 7, 'h77, 'h080, 'h000, 7, 1, 'h77, 0);
    // Backpressure shorter than the timeout
    add(1, 'h001, 'h000, 'h000, 0, 0, 'h00, 'h000, 'h001, 0, 0, 'h00, 0);
    add(0, 'h001, 'h001, 'h000, 0, 0, 'h61, 'h001, 'h001, 0, 1, 'h61, 0);
    add(0, 'h001, 'h001, 'h000, 1, 0, 'h62, 'h000, 'h001, 0, 0, 'h61, 0);
    add(0, 'h001, 'h001, 'h000, 1, 0, 'h62, 'h000, 'h001, 0, 0, 'h61, 0);
    add(0, 'h001, 'h001, 'h000, 0, 0, 'h62, 'h001, 'h001, 0, 1, 'h62, 0);
    add(0, 'h001, 'h001, 'h001, 0, 0, 'h63, 'h001, 'h000, 0, 1, 'h63, 0);

    do_reset();
    chk("reset grant", 32'(grant), 32'h0);
    chk("reset grant_id", 32'(grant_id), 32'h0);
    chk("reset fifo_wr", 32'(fifo_wr), 32'h0);
    chk("reset fifo_wdata", 32'(fifo_wdata), 32'h0);
    chk("reset timeout_pulse", 32'(timeout_pulse), 32'h0);

    foreach (tbl[k]) begin
      if (tbl[k].rst) do_reset();
      drive(tbl[k].bs, tbl[k].v, tbl[k].e, tbl[k].af, tbl[k].tgt, tbl[k].w);
      #1;
      chk($sformatf("v%0d fd_ready", k), 32'(fd_ready), 32'(tbl[k].rdy));
      tick();
      chk($sformatf("v%0d grant", k), 32'(grant), 32'(tbl[k].gnt));
      chk($sformatf("v%0d grant_id", k), 32'(grant_id), 32'(tbl[k].gid));
      chk($sformatf("v%0d fifo_wr", k), 32'(fifo_wr), 32'(tbl[k].wr));
      chk($sformatf("v%0d fifo_wdata", k), 32'(fifo_wdata), 32'(tbl[k].wd));
      chk($sformatf("v%0d timeout_pulse", k), 32'(timeout_pulse), 32'(tbl[k].to));
    end

    // Stall longer than TIMEOUT=3 forces a release with a pulse
    do_reset();
    drive('h002, 'h000, 'h000, 0, 0, 'h00); tick();
    chk("to grant", 32'(grant), 32'h002);
    drive('h002, 'h002, 'h000, 0, 1, 'h51); tick();
    chk("to first word", 32'(fifo_wdata), 32'h51);
    for (int s = 1; s <= 3; s++) begin
      drive('h002, 'h002, 'h000, 1, 1, 'h52);
      #1;
      chk($sformatf("to stall%0d ready", s), 32'(fd_ready), 32'h0);
      tick();
      chk($sformatf("to stall%0d fifo_wr", s), 32'(fifo_wr), 32'h0);
      chk($sformatf("to stall%0d pulse", s), 32'(timeout_pulse), (s == 3) ? 32'h1 : 32'h0);
      chk($sformatf("to stall%0d grant", s), 32'(grant), (s == 3) ? 32'h0 : 32'h002);
    end
    chk("to wdata held", 32'(fifo_wdata), 32'h51);
    drive('h002, 'h002, 'h000, 1, 1, 'h52); tick();
    chk("to pulse one cycle", 32'(timeout_pulse), 32'h0);
    chk("to regrant", 32'(grant), 32'h002);
    drive('h002, 'h002, 'h002, 0, 1, 'h52); tick();
    chk("to resent word", 32'(fifo_wdata), 32'h52);
    chk("to resent wr", 32'(fifo_wr), 32'h1);
    chk("to resent release", 32'(grant), 32'h0);

    // Asynchronous reset between edges mid-packet
    do_reset();
    drive('h004, 'h000, 'h000, 0, 0, 'h00); tick();
    chk("ar grant before", 32'(grant), 32'h004);
    drive('h004, 'h004, 'h000, 0, 2, 'h5A); tick();
    chk("ar wr before", 32'(fifo_wr), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar grant", 32'(grant), 32'h0);
    chk("ar grant_id", 32'(grant_id), 32'h0);
    chk("ar fifo_wr", 32'(fifo_wr), 32'h0);
    chk("ar fifo_wdata", 32'(fifo_wdata), 32'h0);
    chk("ar pulse", 32'(timeout_pulse), 32'h0);
    chk("ar fd_ready", 32'(fd_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive('h3FF, 'h000, 'h000, 0, 0, 'h00);
    tick();
    chk("ar regrant", 32'(grant), 32'h001);
    chk("ar regrant id", 32'(grant_id), 32'h0);

    // Random traffic against the reference model
    do_reset();
    m_busy = 0; m_gid = 0; m_rr = N - 1; m_idle = 0; m_wr = 0; m_wd = 8'h00; m_to = 0;
    bus_sel = '0;
    for (int c = 0; c < 1500; c++) begin
      logic [7:0]   d [N];
      logic [N-1:0] exp_rdy, exp_gnt;
      bit           xf, rel, n_wr, n_to;
      if ($urandom_range(0, 3) == 0) bus_sel = N'($urandom);
      fd_valid   = N'($urandom);
      fd_eop     = N'($urandom & $urandom);
      fifo_afull = ($urandom_range(0, 4) == 0);
      for (int x = 0; x < N; x++) begin
        d[x] = 8'($urandom);
        fd_data[x*DW +: DW] = d[x];
      end
      #1;
      exp_rdy = (m_busy && !fifo_afull) ? (N'(1) << m_gid) : '0;
      chk($sformatf("rnd%0d fd_ready", c), 32'(fd_ready), 32'(exp_rdy));

      n_wr = 0; n_to = 0; rel = 0;
      if (m_busy) begin
        xf = fd_valid[IW'(m_gid)] && !fifo_afull;
        if (xf) begin
          n_wr = 1;
          m_wd = d[IW'(m_gid)];
          m_idle = 0;
          if (fd_eop[IW'(m_gid)]) rel = 1;
        end else begin
          if (m_idle < TO) m_idle++;
          if (TO != 0 && m_idle == TO) begin
            rel = 1;
            n_to = 1;
          end else if (!bus_sel[IW'(m_gid)]) begin
            rel = 1;
          end
        end
        if (rel) begin
          m_busy = 0;
          m_rr = m_gid;
        end
      end else if (bus_sel != '0) begin
        for (int k = 1; k <= N; k++) begin
          int cand;
          cand = (m_rr + k) % N;
          if (bus_sel[IW'(cand)]) begin
            m_gid = cand;
            m_busy = 1;
            m_idle = 0;
            break;
          end
        end
      end
      m_wr = n_wr;
      m_to = n_to;

      tick();
      exp_gnt = m_busy ? (N'(1) << m_gid) : '0;
      chk($sformatf("rnd%0d grant", c), 32'(grant), 32'(exp_gnt));
      chk($sformatf("rnd%0d grant_id", c), 32'(grant_id), 32'(m_gid));
      chk($sformatf("rnd%0d fifo_wr", c), 32'(fifo_wr), 32'(m_wr));
      chk($sformatf("rnd%0d fifo_wdata", c), 32'(fifo_wdata), 32'(m_wd));
      chk($sformatf("rnd%0d timeout_pulse", c), 32'(timeout_pulse), 32'(m_to));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
